xseq_chk: RTL and testbench

//  Downstream consumer of the pipelined counter stage (outputs x[7:0], y; enable cnt).

---
 rtl/xseq_pkg.sv | 15 +
 rtl/xseq_chk_sat_ctr.sv | 35 +++
 rtl/xseq_chk.sv | 162 ++++++++++++++++
 tb/tb_xseq_chk.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/xseq_pkg.sv
// Shared definitions for the x-sequence checker.
// Holds the FSM state type and the default widths and latency used by
// xseq_chk and its saturating counter.
package xseq_pkg;

    localparam int W_DEF    = 8;   // width of x and of the compare datapath
    localparam int LAT_DEF  = 2;   // edges from sampling cnt to the matching x step
    localparam int ERRW_DEF = 8;   // width of the violation counters

    typedef enum logic [0:0] {
        SYNC  = 1'b0,
        CHECK = 1'b1
    } st_t;

endpackage

// File: rtl/xseq_chk_sat_ctr.sv
// Saturating up-counter used for the violation counts.
// Ports:
//   clka  in   clock, rising edge
//   clr   in   synchronous clear, active-high, wins over inc
//   inc   in   count one event this edge
//   q     out  registered count; holds at all-ones
module sat_ctr
    import xseq_pkg::*;
#(
    parameter int ERRW = ERRW_DEF
) (
    input  logic            clka,
    input  logic            clr,
    input  logic            inc,
    output logic [ERRW-1:0] q
);

    localparam logic [ERRW-1:0] MAX_V = {ERRW{1'b1}};

    logic [ERRW-1:0] q_r;

    // Count register: clear, increment below the ceiling, otherwise hold.
    always_ff @(posedge clka) begin
        if (clr) begin
            q_r <= '0;
        end else if (inc && (q_r != MAX_V)) begin
            q_r <= q_r + ERRW'(1);
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/xseq_chk.sv
// Downstream checker for the pipelined counter stage.
// Verifies that x advances by exactly the cnt value sampled LAT edges
// earlier (mod 2^W) and that the glitch flag y stays low. Violations are
// counted (saturating), flagged sticky, and the first x mismatch is kept.
// Ports:
//   clka     in   sole clock, rising edge
//   rst      in   synchronous reset, active-high
//   cnt      in   enable that drives the upstream counter
//   x        in   upstream counter value
//   y        in   upstream glitch flag
//   locked   out  1 while checking
//   err      out  sticky violation flag
//   err_cnt  out  saturating count of x-step mismatches
//   gl_cnt   out  saturating count of locked cycles with y==1
//   bad_x    out  x at first mismatch
//   bad_exp  out  expected value at first mismatch
module xseq_chk
    import xseq_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int LAT  = LAT_DEF,
    parameter int ERRW = ERRW_DEF
) (
    input  logic            clka,
    input  logic            rst,
    input  logic            cnt,
    input  logic [W-1:0]    x,
    input  logic            y,
    output logic            locked,
    output logic            err,
    output logic [ERRW-1:0] err_cnt,
    output logic [ERRW-1:0] gl_cnt,
    output logic [W-1:0]    bad_x,
    output logic [W-1:0]    bad_exp
);

    localparam int            FW       = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam logic [FW-1:0] FILL_END = FW'(LAT);

    st_t             st_r;
    st_t             st_nx_s;
    logic [FW-1:0]   fill_r;
    logic [FW-1:0]   fill_nx_s;
    logic [LAT-1:0]  cnt_d_r;
    logic [W-1:0]    x_prev_r;
    logic            cnt_dl_s;
    logic [W-1:0]    exp_s;
    logic            mism_s;
    logic            glitch_s;
    logic            locked_r;
    logic            err_r;
    logic            cap_r;
    logic [W-1:0]    bad_x_r;
    logic [W-1:0]    bad_exp_r;

    // cnt delay line: cnt_d_r[i] holds cnt as sampled i+1 edges ago.
    always_ff @(posedge clka) begin
        if (rst) begin
            cnt_d_r <= '0;
        end else begin
            cnt_d_r[0] <= cnt;
            for (int i = 1; i < LAT; i++) begin
                cnt_d_r[i] <= cnt_d_r[i-1];
            end
        end
    end

    // Previous x, the baseline for the next compare; it follows the
    // observed value so a single bad sample costs only one error.
    always_ff @(posedge clka) begin
        x_prev_r <= x;
    end

    // Step compare and glitch detect, active only while checking.
    always_comb begin
        cnt_dl_s = cnt_d_r[LAT-1];
        exp_s    = x_prev_r + W'(cnt_dl_s);
        if (st_r == CHECK) begin
            mism_s   = (x != exp_s);
            glitch_s = y;
        end else begin
            mism_s   = 1'b0;
            glitch_s = 1'b0;
        end
    end

    // FSM state and fill counter registers.
    always_ff @(posedge clka) begin
        if (rst) begin
            st_r   <= SYNC;
            fill_r <= '0;
        end else begin
            st_r   <= st_nx_s;
            fill_r <= fill_nx_s;
        end
    end

    // FSM next state: wait LAT+1 edges for the delay line to fill, then check.
    always_comb begin
        st_nx_s   = st_r;
        fill_nx_s = fill_r;
        case (st_r)
            SYNC: begin
                if (fill_r == FILL_END) begin
                    st_nx_s = CHECK;
                end else begin
                    fill_nx_s = fill_r + FW'(1);
                end
            end
            CHECK: begin
                st_nx_s = CHECK;
            end
            default: begin
                st_nx_s   = SYNC;
                fill_nx_s = '0;
            end
        endcase
    end

    // Status registers: lock flag, sticky error and first-mismatch capture.
    always_ff @(posedge clka) begin
        if (rst) begin
            locked_r  <= 1'b0;
            err_r     <= 1'b0;
            cap_r     <= 1'b0;
            bad_x_r   <= '0;
            bad_exp_r <= '0;
        end else begin
            locked_r <= (st_nx_s == CHECK);
            err_r    <= err_r | mism_s | glitch_s;
            if (mism_s && !cap_r) begin
                cap_r     <= 1'b1;
                bad_x_r   <= x;
                bad_exp_r <= exp_s;
            end else begin
                cap_r     <= cap_r;
                bad_x_r   <= bad_x_r;
                bad_exp_r <= bad_exp_r;
            end
        end
    end

    sat_ctr #(.ERRW(ERRW)) u_err_ctr (
        .clka (clka),
        .clr  (rst),
        .inc  (mism_s),
        .q    (err_cnt)
    );

    sat_ctr #(.ERRW(ERRW)) u_gl_ctr (
        .clka (clka),
        .clr  (rst),
        .inc  (glitch_s),
        .q    (gl_cnt)
    );

    assign locked  = locked_r;
    assign err     = err_r;
    assign bad_x   = bad_x_r;
    assign bad_exp = bad_exp_r;

endmodule

// File: tb/tb_xseq_chk.sv
// Bench for xseq_chk: drives a model of the upstream counter stage and
// compares every cycle's outputs against a queue of expected values
// produced by an edge-counting reference model.
module tb_xseq_chk;

    localparam int LAT    = 2;
    localparam int MAXCNT = 255;

    logic       clka = 1'b0;
    logic       rst  = 1'b1;
    logic       cnt  = 1'b0;
    logic [7:0] x    = 8'h00;
    logic       y    = 1'b0;
    logic       locked, err;
    logic [7:0] err_cnt, gl_cnt, bad_x, bad_exp;

    always #5 clka = ~clka;

    xseq_chk #(.W(8), .LAT(LAT), .ERRW(8)) dut (
        .clka    (clka),
        .rst     (rst),
        .cnt     (cnt),
        .x       (x),
        .y       (y),
        .locked  (locked),
        .err     (err),
        .err_cnt (err_cnt),
        .gl_cnt  (gl_cnt),
        .bad_x   (bad_x),
        .bad_exp (bad_exp)
    );

    typedef struct packed {
        logic       locked;
        logic       err;
        logic [7:0] err_cnt;
        logic [7:0] gl_cnt;
        logic [7:0] bad_x;
        logic [7:0] bad_exp;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: edges since reset, recent history, counters.
    int   m_k   = 0;
    int   m_x1  = 0;
    int   m_ch[$];
    int   m_ec  = 0;
    int   m_gc  = 0;
    bit   m_err = 1'b0;
    bit   m_cap = 1'b0;
    int   m_bx  = 0;
    int   m_be  = 0;

    // Upstream stage model: r0 <= cnt; x <= x + r0.
    logic [7:0] up_x     = 8'h00;
    logic       up_r0    = 1'b0;
    logic       prev_rst = 1'b1;
    logic       prev_cnt = 1'b0;

    function automatic obs_t model_edge(input bit r, input bit c, input int xv, input bit yv);
        obs_t o;
        int   e;
        int   dl;
        if (r) begin
            m_k = 0; m_ec = 0; m_gc = 0; m_err = 1'b0; m_cap = 1'b0;
            m_bx = 0; m_be = 0;
            m_ch.delete();
            for (int i = 0; i < LAT; i++) m_ch.push_back(0);
        end else begin
            dl = m_ch[0];
            if (m_k >= LAT + 1) begin
                e = (m_x1 + dl) % 256;
                if (xv != e) begin
                    if (m_ec < MAXCNT) m_ec++;
                    m_err = 1'b1;
                    if (!m_cap) begin
                        m_cap = 1'b1; m_bx = xv; m_be = e;
                    end
                end
                if (yv) begin
                    if (m_gc < MAXCNT) m_gc++;
                    m_err = 1'b1;
                end
            end
            m_ch.push_back(int'(c));
            void'(m_ch.pop_front());
            if (m_k < 1000) m_k++;
        end
        m_x1 = xv;
        o.locked  = (m_k >= LAT + 1);
        o.err     = m_err;
        o.err_cnt = 8'(m_ec);
        o.gl_cnt  = 8'(m_gc);
        o.bad_x   = 8'(m_bx);
        o.bad_exp = 8'(m_be);
        return o;
    endfunction

    // One cycle of stimulus; fx forces the upstream x register to fv.
    task automatic drive(input bit r, input bit c, input bit fx, input logic [7:0] fv, input bit yv);
        @(negedge clka);
        if (prev_rst) begin
            up_x  = 8'h00;
            up_r0 = 1'b0;
        end else begin
            up_x  = up_x + {7'd0, up_r0};
            up_r0 = prev_cnt;
        end
        if (fx) up_x = fv;
        rst = r; cnt = c; x = up_x; y = yv;
        exp_q.push_back(model_edge(r, c, int'(up_x), yv));
        prev_rst = r;
        prev_cnt = c;
    endtask

    task automatic settle();
        @(posedge clka);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    // Monitor: after each edge, compare outputs with the next expected entry.
    initial begin
        obs_t e;
        obs_t g;
        forever begin
            @(posedge clka);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = '{locked, err, err_cnt, gl_cnt, bad_x, bad_exp};
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t: got lk=%b err=%b ec=%0h gc=%0h bx=%0h be=%0h expected lk=%b err=%b ec=%0h gc=%0h bx=%0h be=%0h",
                             $time, g.locked, g.err, g.err_cnt, g.gl_cnt, g.bad_x, g.bad_exp,
                             e.locked, e.err, e.err_cnt, e.gl_cnt, e.bad_x, e.bad_exp);
                end
            end
        end
    end

    initial begin
        int n;
        // 1: reset, then cnt=1 long enough to wrap x.
        drive(1, 1, 0, 8'h00, 0);
        settle();
        chk("reset_locked", int'(locked), 0);
        chk("reset_err", int'(err), 0);
        drive(0, 1, 0, 8'h00, 0);
        drive(0, 1, 0, 8'h00, 0);
        settle();
        chk("lock_after_2", int'(locked), 0);
        drive(0, 1, 0, 8'h00, 0);
        settle();
        chk("lock_after_3", int'(locked), 1);
        for (int i = 0; i < 297; i++) drive(0, 1, 0, 8'h00, 0);
        settle();
        chk("wrap_err", int'(err), 0);
        chk("wrap_err_cnt", int'(err_cnt), 0);

        // 2: alternating cnt.
        for (int i = 0; i < 50; i++) drive(0, (i % 2) == 0, 0, 8'h00, 0);
        settle();
        chk("toggle_err", int'(err), 0);

        // 3: one bad sample where 0x11 is expected.
        n = 0;
        while ((8'(up_x + {7'd0, up_r0}) != 8'h11) && (n < 300)) begin
            drive(0, 1, 0, 8'h00, 0);
            n++;
        end
        chk("find_0x11", int'(n < 300), 1);
        drive(0, 1, 1, 8'h20, 0);
        for (int i = 0; i < 40; i++) drive(0, 1'($urandom_range(0, 1)), 0, 8'h00, 0);
        settle();
        chk("single_err_cnt", int'(err_cnt), 1);
        chk("single_bad_x", int'(bad_x), 8'h20);
        chk("single_bad_exp", int'(bad_exp), 8'h11);
        chk("single_err", int'(err), 1);

        // 4: three glitch cycles.
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 8'h00, 1);
        drive(0, 1, 0, 8'h00, 0);
        settle();
        chk("glitch_gl_cnt", int'(gl_cnt), 3);
        chk("glitch_err_cnt", int'(err_cnt), 1);

        // 5: x stuck at 0x05 with cnt=1.
        for (int i = 0; i < 300; i++) drive(0, 1, 1, 8'h05, 0);
        settle();
        chk("sat_err_cnt", int'(err_cnt), 255);
        chk("sat_bad_x", int'(bad_x), 8'h20);
        chk("sat_bad_exp", int'(bad_exp), 8'h11);
        chk("sat_gl_cnt", int'(gl_cnt), 3);

        // 6: reset while in error.
        drive(1, 1, 0, 8'h00, 0);
        settle();
        chk("rst_all_zero", int'({locked, err, err_cnt, gl_cnt, bad_x, bad_exp}), 0);
        drive(0, 1, 0, 8'h00, 0);
        drive(0, 0, 0, 8'h00, 0);
        settle();
        chk("relock_after_2", int'(locked), 0);
        drive(0, 1, 0, 8'h00, 0);
        settle();
        chk("relock_after_3", int'(locked), 1);

        // Random traffic with occasional faults and resets.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 149) == 0,
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 24) == 0,
                  8'($urandom_range(0, 255)),
                  $urandom_range(0, 29) == 0);
        end
        settle();
        @(posedge clka);
        #2;
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
